// File: rtl/mem_line_pkg.sv
// Shared types and constants for the 128-bit line memory responder.
// Holds the transaction state encoding and the line geometry.
package mem_line_pkg;

    localparam int LINE_BYTES = 16;
    localparam int LINE_BITS  = 128;
    localparam int OFFS_BITS  = 4;
    localparam int CNT_W      = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STALL  = 3'd1,
        ACCEPT = 3'd2,
        RD_LAT = 3'd3,
        RESP   = 3'd4
    } state_t;

endpackage

// File: rtl/mem_line_responder_ram.sv
// Single-port line store: synchronous write, registered synchronous read.
// Contents are deliberately not reset.
module line_ram #(
    parameter int WIDTH   = 128,
    parameter int WIDTHAD = 10
) (
    input  logic               clk,
    input  logic               we,
    input  logic               re,
    input  logic [WIDTHAD-1:0] addr,
    input  logic [WIDTH-1:0]   wdata,
    output logic [WIDTH-1:0]   rdata
);

    logic [WIDTH-1:0] mem_r [0:(1<<WIDTHAD)-1];

    // Line write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Registered read port; output holds between reads
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem_r[addr];
        end
    end

endmodule

// File: rtl/mem_line_responder.sv
// Memory-side responder for the cache line interface: stalls with waitrequest,
// stores lines in a local RAM and returns reads after a fixed latency.
module mem_line_responder
    import mem_line_pkg::*;
#(
    parameter int LINE_AW      = 10,
    parameter int ACCEPT_WAIT  = 1,
    parameter int READ_LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          i_m_addr,
    input  logic [LINE_BITS-1:0] i_m_writedata,
    input  logic                 i_m_read,
    input  logic                 i_m_write,
    output logic [LINE_BITS-1:0] o_m_readdata,
    output logic                 o_m_readdata_valid,
    output logic                 o_m_waitrequest,
    output logic                 o_proto_err,
    output logic [31:0]          cnt_rd,
    output logic [31:0]          cnt_wr
);

    localparam logic [CNT_W-1:0] AW_C = CNT_W'(ACCEPT_WAIT);
    localparam logic [CNT_W-1:0] RL_C = CNT_W'(READ_LATENCY);

    state_t               state_r, state_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic                 is_rd_r, is_rd_s;
    logic                 req_s;
    logic                 ram_we_s, ram_re_s, resp_s, err_s;
    logic [LINE_AW-1:0]   line_s;
    logic [LINE_BITS-1:0] ram_q_s;
    logic                 addr_unused;

    // Upper address bits alias onto the same line; offset bits are ignored
    assign line_s      = i_m_addr[LINE_AW+OFFS_BITS-1:OFFS_BITS];
    assign addr_unused = ^{i_m_addr[31:LINE_AW+OFFS_BITS], i_m_addr[OFFS_BITS-1:0]};

    // Next-state, counter and strobe decode
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        is_rd_s  = is_rd_r;
        ram_we_s = 1'b0;
        ram_re_s = 1'b0;
        resp_s   = 1'b0;
        err_s    = 1'b0;
        req_s    = is_rd_r ? i_m_read : i_m_write;
        case (state_r)
            IDLE: begin
                if (i_m_read || i_m_write) begin
                    // a read wins over a simultaneous write
                    is_rd_s = i_m_read;
                    err_s   = i_m_read & i_m_write;
                    cnt_s   = AW_C;
                    state_s = (ACCEPT_WAIT == 0) ? ACCEPT : STALL;
                end else begin
                    state_s = IDLE;
                end
            end
            STALL: begin
                if (!req_s) begin
                    err_s   = 1'b1;
                    state_s = IDLE;
                end else begin
                    cnt_s   = cnt_r - CNT_W'(1);
                    state_s = (cnt_r == CNT_W'(1)) ? ACCEPT : STALL;
                end
            end
            ACCEPT: begin
                if (!req_s) begin
                    err_s   = 1'b1;
                    state_s = IDLE;
                end else if (is_rd_r) begin
                    ram_re_s = 1'b1;
                    cnt_s    = RL_C;
                    state_s  = (READ_LATENCY == 1) ? RESP : RD_LAT;
                end else begin
                    ram_we_s = 1'b1;
                    state_s  = IDLE;
                end
            end
            RD_LAT: begin
                // RESP is the cycle before the valid pulse, hence the compare with 2
                cnt_s   = cnt_r - CNT_W'(1);
                state_s = (cnt_r == CNT_W'(2)) ? RESP : RD_LAT;
            end
            RESP: begin
                resp_s  = 1'b1;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, handshake outputs, sticky error and transaction counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r            <= IDLE;
            cnt_r              <= '0;
            is_rd_r            <= 1'b0;
            o_m_waitrequest    <= 1'b1;
            o_m_readdata_valid <= 1'b0;
            o_m_readdata       <= '0;
            o_proto_err        <= 1'b0;
            cnt_rd             <= 32'd0;
            cnt_wr             <= 32'd0;
        end else begin
            state_r            <= state_s;
            cnt_r              <= cnt_s;
            is_rd_r            <= is_rd_s;
            o_m_waitrequest    <= (state_s != ACCEPT);
            o_m_readdata_valid <= resp_s;
            if (resp_s) begin
                o_m_readdata <= ram_q_s;
            end
            if (err_s) begin
                o_proto_err <= 1'b1;
            end
            if (ram_we_s) begin
                cnt_wr <= cnt_wr + 32'd1;
            end
            if (ram_re_s) begin
                cnt_rd <= cnt_rd + 32'd1;
            end
        end
    end

    line_ram #(
        .WIDTH   (LINE_BITS),
        .WIDTHAD (LINE_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .re    (ram_re_s),
        .addr  (line_s),
        .wdata (i_m_writedata),
        .rdata (ram_q_s)
    );

endmodule

// File: tb/tb_mem_line_responder.sv
// Self-checking bench: three responder instances with different timing,
// a directed vector table, corner-case sequences and a randomized run.
module tb_mem_line_responder;

    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    int           cyc = 0;
    logic [31:0]  m_addr  [N];
    logic [127:0] m_wdata [N];
    logic         m_read  [N];
    logic         m_write [N];
    logic [127:0] rdata   [N];
    logic         rvalid  [N];
    logic         wreq    [N];
    logic         perr    [N];
    logic [31:0]  crd     [N];
    logic [31:0]  cwr     [N];

    int checks = 0;
    int failures = 0;

    // reference model: line contents and expected counters per instance
    logic [127:0] mdl [N][1024];
    int           e_rd [N];
    int           e_wr [N];
    logic         e_err [N];

    function automatic int aw_of(input int k);
        case (k)
            0: return 1;
            1: return 0;
            default: return 4;
        endcase
    endfunction

    function automatic int rl_of(input int k);
        case (k)
            0: return 3;
            1: return 1;
            default: return 5;
        endcase
    endfunction

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 4) % 32'd1024);
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        mem_line_responder #(
            .LINE_AW      (10),
            .ACCEPT_WAIT  (aw_of(g)),
            .READ_LATENCY (rl_of(g))
        ) dut (
            .clk                (clk),
            .rst                (rst),
            .i_m_addr           (m_addr[g]),
            .i_m_writedata      (m_wdata[g]),
            .i_m_read           (m_read[g]),
            .i_m_write          (m_write[g]),
            .o_m_readdata       (rdata[g]),
            .o_m_readdata_valid (rvalid[g]),
            .o_m_waitrequest    (wreq[g]),
            .o_proto_err        (perr[g]),
            .cnt_rd             (crd[g]),
            .cnt_wr             (cwr[g])
        );
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input int k);
        chk("rst_wait", wreq[k], 1);
        chk("rst_valid", rvalid[k], 0);
        chk("rst_rdata", rdata[k], 0);
        chk("rst_err", perr[k], 0);
        chk("rst_cnt_rd", crd[k], 0);
        chk("rst_cnt_wr", cwr[k], 0);
    endtask

    // One complete transaction with timing checked against the parameters
    task automatic txn(input int k, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [127:0] d, output logic [127:0] got);
        int e0, low_at, ea, v_at;
        logic [127:0] exp;
        got = '0;
        @(negedge clk);
        m_addr[k] = a; m_wdata[k] = d; m_read[k] = rd; m_write[k] = wr;
        e0 = cyc + 1;
        low_at = -1;
        for (int i = 0; i < 300 && low_at < 0; i++) begin
            @(negedge clk);
            if (!wreq[k]) low_at = cyc;
        end
        chk("wait_low_edge", low_at, e0 + aw_of(k));
        @(negedge clk);
        ea = cyc;
        m_read[k] = 1'b0; m_write[k] = 1'b0;
        chk("wait_high_at_ea", wreq[k], 1);
        if (rd) begin
            e_rd[k]++;
            if (wr) e_err[k] = 1'b1;
            exp = mdl[k][line_of(a)];
            v_at = -1;
            for (int i = 0; i < 300 && v_at < 0; i++) begin
                @(negedge clk);
                if (rvalid[k]) begin
                    v_at = cyc;
                    got = rdata[k];
                end
            end
            chk("valid_edge", v_at, ea + rl_of(k));
            chk("read_data", got, exp);
            @(negedge clk);
            chk("valid_one_cycle", rvalid[k], 0);
        end else begin
            mdl[k][line_of(a)] = d;
            e_wr[k]++;
        end
        chk("cnt_rd", crd[k], e_rd[k]);
        chk("cnt_wr", cwr[k], e_wr[k]);
        chk("proto_err", perr[k], e_err[k]);
    endtask

    typedef struct {
        bit           rd;
        bit           wr;
        logic [31:0]  addr;
        logic [127:0] wdata;
        logic [127:0] exp;
    } vec_t;

    localparam logic [127:0] C0 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] D0 = 128'hDEADBEEF_00000001_CAFEF00D_12345678;
    localparam logic [127:0] E0 = 128'h5555AAAA_5555AAAA_5555AAAA_5555AAAA;
    localparam logic [127:0] F0 = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000;

    vec_t         tbl [7];
    logic [127:0] got;
    int           n, nv, acc, low_cnt, vs;
    bit           prev_low;
    int           v_at [2];
    int           ea_at [2];
    logic [127:0] v_d [2];

    initial begin
        for (int k = 0; k < N; k++) begin
            m_addr[k] = 32'd0; m_wdata[k] = 128'd0; m_read[k] = 1'b0; m_write[k] = 1'b0;
            e_rd[k] = 0; e_wr[k] = 0; e_err[k] = 1'b0;
            for (int i = 0; i < 1024; i++) mdl[k][i] = 128'd0;
        end
        tbl[0] = '{1'b0, 1'b1, 32'h0000_0040, C0, 128'd0};
        tbl[1] = '{1'b1, 1'b0, 32'h0000_0048, 128'd0, C0};
        tbl[2] = '{1'b0, 1'b1, 32'h0000_4010, D0, 128'd0};
        tbl[3] = '{1'b1, 1'b0, 32'h0000_0010, 128'd0, D0};
        tbl[4] = '{1'b0, 1'b1, 32'h0000_0080, E0, 128'd0};
        tbl[5] = '{1'b1, 1'b1, 32'h0000_0080, F0, E0};
        tbl[6] = '{1'b1, 1'b0, 32'h0000_0080, 128'd0, E0};

        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++) chk_reset(k);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < N; k++) chk_reset(k);

        // directed table on the default-timing instance
        for (int i = 0; i < 7; i++) begin
            txn(0, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, got);
            if (tbl[i].rd) chk("tbl_data", got, tbl[i].exp);
        end
        chk("tbl_cnt_wr", cwr[0], 3);
        chk("tbl_err", perr[0], 1);

        // back-to-back reads with the read request held continuously
        txn(1, 1'b0, 1'b1, 32'h0000_0000, {32{4'hA}}, got);
        txn(1, 1'b0, 1'b1, 32'h0000_0010, {32{4'hB}}, got);
        @(negedge clk);
        m_addr[1] = 32'h0; m_read[1] = 1'b1;
        n = cyc; nv = 0; acc = 0; prev_low = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rvalid[1]) begin
                if (nv < 2) begin v_at[nv] = cyc; v_d[nv] = rdata[1]; end
                nv++;
            end
            if (prev_low) begin
                if (acc < 2) ea_at[acc] = cyc;
                acc++;
                if (acc == 1) m_addr[1] = 32'h10;
                else m_read[1] = 1'b0;
            end
            prev_low = !wreq[1];
        end
        e_rd[1] += 2;
        chk("b2b_pulses", nv, 2);
        chk("b2b_accepts", acc, 2);
        chk("b2b_ea0", ea_at[0], n + 2);
        chk("b2b_v0", v_at[0], n + 3);
        chk("b2b_d0", v_d[0], {32{4'hA}});
        chk("b2b_ea1", ea_at[1], n + 5);
        chk("b2b_v1", v_at[1], n + 6);
        chk("b2b_d1", v_d[1], {32{4'hB}});
        chk("b2b_cnt_rd", crd[1], e_rd[1]);

        // request withdrawn during the stall window
        @(negedge clk);
        m_addr[2] = 32'h30; m_read[2] = 1'b1;
        repeat (2) @(negedge clk);
        m_read[2] = 1'b0;
        nv = 0; low_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (rvalid[2]) nv++;
            if (!wreq[2]) low_cnt++;
        end
        e_err[2] = 1'b1;
        chk("abort_no_valid", nv, 0);
        chk("abort_no_accept", low_cnt, 0);
        chk("abort_cnt_rd", crd[2], e_rd[2]);
        chk("abort_err", perr[2], 1);
        txn(2, 1'b0, 1'b1, 32'h0000_0030, D0, got);

        // reset while a read is in its latency window
        @(negedge clk);
        m_addr[0] = 32'h40; m_read[0] = 1'b1;
        repeat (3) @(negedge clk);
        m_read[0] = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_reset(0);
        chk_reset(2);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < N; k++) begin e_rd[k] = 0; e_wr[k] = 0; e_err[k] = 1'b0; end
        vs = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rvalid[0]) vs++;
        end
        chk("rst_no_valid", vs, 0);
        txn(0, 1'b1, 1'b0, 32'h0000_0044, 128'd0, got);
        chk("rst_ram_kept", got, C0);

        // randomized traffic against the model
        for (int k = 0; k < N; k++) begin
            for (int l = 0; l < 16; l++)
                txn(k, 1'b0, 1'b1, ($urandom & 32'hFFFF_C00F) | (l << 4),
                    {$urandom, $urandom, $urandom, $urandom}, got);
            for (int t = 0; t < 25; t++) begin
                bit rd;
                rd = ($urandom_range(0, 1) == 1);
                txn(k, rd, !rd, ($urandom & 32'hFFFF_C00F) | ($urandom_range(0, 15) << 4),
                    {$urandom, $urandom, $urandom, $urandom}, got);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
